// File: rtl/ctrl_pipe_pkg.sv
// Shared control encodings for the DEC/EX/MEM/WB control pipeline.
// Latency: none (constants, types, and one pure helper function).
// Backpressure: not applicable.
package ctrl_pipe_pkg;

    // Major opcodes (insn[6:0])
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // funct3 for the integer ALU group
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // funct7 variants
    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;

    // ALU operation codes
    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_SLL    = 5'd2;
    localparam logic [4:0] ALU_SLT    = 5'd3;
    localparam logic [4:0] ALU_SLTU   = 5'd4;
    localparam logic [4:0] ALU_XOR    = 5'd5;
    localparam logic [4:0] ALU_SRL    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_OR     = 5'd8;
    localparam logic [4:0] ALU_AND    = 5'd9;
    localparam logic [4:0] ALU_COPYB  = 5'd10;
    // M-extension codes are 5'b10_<funct3> so decode can splice funct3 in.
    localparam logic [4:0] ALU_MUL    = 5'd16;
    localparam logic [4:0] ALU_MULH   = 5'd17;
    localparam logic [4:0] ALU_MULHSU = 5'd18;
    localparam logic [4:0] ALU_MULHU  = 5'd19;
    localparam logic [4:0] ALU_DIV    = 5'd20;
    localparam logic [4:0] ALU_DIVU   = 5'd21;
    localparam logic [4:0] ALU_REM    = 5'd22;
    localparam logic [4:0] ALU_REMU   = 5'd23;

    // Writeback source select
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    // immsel: instruction carries an immediate; rs1sel: operand A is PC;
    // rs2sel: operand B is the immediate.
    typedef struct packed {
        logic       pcsel;
        logic       immsel;
        logic       regwren;
        logic       rs1sel;
        logic       rs2sel;
        logic       memren;
        logic       memwren;
        logic [1:0] wbsel;
        logic [4:0] alusel;
        logic       is_branch;
        logic [2:0] funct3;
    } ctrl_t;

    // Base ALU op for a funct3 (shift right defaults to logical).
    function automatic logic [4:0] alu_from_f3(input logic [2:0] f3);
        logic [4:0] op;
        case (f3)
            F3_ADD:  op = ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SRL:  op = ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decode into a ctrl_t bundle plus register fields.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; ports: insn in; ctrl, illegal, rd/rs1/rs2, use_rs1/use_rs2 out.
module ctrl_decode
    import ctrl_pipe_pkg::*;
#(
    parameter int EN_M = 0
) (
    input  logic [31:0] insn,
    output ctrl_t       ctrl,
    output logic        illegal,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic        use_rs1,
    output logic        use_rs2
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = insn[6:0];
    assign rd     = insn[11:7];
    assign funct3 = insn[14:12];
    assign rs1    = insn[19:15];
    assign rs2    = insn[24:20];
    assign funct7 = insn[31:25];

    always_comb begin
        ctrl        = '0;
        illegal     = 1'b0;
        use_rs1     = 1'b0;
        use_rs2     = 1'b0;
        ctrl.funct3 = funct3;
        case (opcode)
            OP_REG: begin
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
                ctrl.regwren = 1'b1;
                ctrl.wbsel   = WB_ALU;
                case (funct7)
                    F7_BASE: ctrl.alusel = alu_from_f3(funct3);
                    F7_ALT: begin
                        if (funct3 == F3_ADD)
                            ctrl.alusel = ALU_SUB;
                        else if (funct3 == F3_SRL)
                            ctrl.alusel = ALU_SRA;
                        else
                            illegal = 1'b1;
                    end
                    F7_MULDIV: begin
                        if (EN_M != 0)
                            ctrl.alusel = {2'b10, funct3};
                        else
                            illegal = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OP_IMM: begin
                use_rs1      = 1'b1;
                ctrl.regwren = 1'b1;
                ctrl.immsel  = 1'b1;
                ctrl.rs2sel  = 1'b1;
                ctrl.wbsel   = WB_ALU;
                if (funct3 == F3_SRL && funct7 == F7_ALT)
                    ctrl.alusel = ALU_SRA;
                else
                    ctrl.alusel = alu_from_f3(funct3);
            end
            OP_LOAD: begin
                use_rs1      = 1'b1;
                ctrl.regwren = 1'b1;
                ctrl.immsel  = 1'b1;
                ctrl.rs2sel  = 1'b1;
                ctrl.memren  = 1'b1;
                ctrl.wbsel   = WB_MEM;
                ctrl.alusel  = ALU_ADD;
            end
            OP_STORE: begin
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
                ctrl.immsel  = 1'b1;
                ctrl.rs2sel  = 1'b1;
                ctrl.memwren = 1'b1;
                ctrl.alusel  = ALU_ADD;
            end
            OP_BRANCH: begin
                use_rs1        = 1'b1;
                use_rs2        = 1'b1;
                ctrl.immsel    = 1'b1;
                ctrl.is_branch = 1'b1;
                ctrl.alusel    = ALU_SUB;
            end
            OP_JAL: begin
                ctrl.pcsel   = 1'b1;
                ctrl.regwren = 1'b1;
                ctrl.immsel  = 1'b1;
                ctrl.rs1sel  = 1'b1;
                ctrl.rs2sel  = 1'b1;
                ctrl.wbsel   = WB_PC4;
                ctrl.alusel  = ALU_ADD;
            end
            OP_JALR: begin
                use_rs1      = 1'b1;
                ctrl.pcsel   = 1'b1;
                ctrl.regwren = 1'b1;
                ctrl.immsel  = 1'b1;
                ctrl.rs2sel  = 1'b1;
                ctrl.wbsel   = WB_PC4;
                ctrl.alusel  = ALU_ADD;
            end
            OP_LUI: begin
                ctrl.regwren = 1'b1;
                ctrl.immsel  = 1'b1;
                ctrl.rs2sel  = 1'b1;
                ctrl.alusel  = ALU_COPYB;
            end
            OP_AUIPC: begin
                ctrl.regwren = 1'b1;
                ctrl.immsel  = 1'b1;
                ctrl.rs1sel  = 1'b1;
                ctrl.rs2sel  = 1'b1;
                ctrl.alusel  = ALU_ADD;
            end
            default: illegal = 1'b1;
        endcase

        // Illegal instructions travel as an all-zero NOP bundle and claim no
        // source registers, so they can never raise a load-use hazard.
        if (illegal) begin
            ctrl    = '0;
            use_rs1 = 1'b0;
            use_rs2 = 1'b0;
        end else if (rd == 5'd0) begin
            ctrl.regwren = 1'b0;
        end
    end

endmodule

// File: rtl/ctrl_pipe.sv
// DEC->EX->MEM->WB control pipeline with load-use hazard detection and retire counter.
// Latency: insn_i to ex_* 1 cycle, to wb_* 3 cycles.
// Backpressure: stall_i freezes every stage; hazard_o asks decode to hold insn_i one cycle.
module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int EN_M   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DWIDTH-1:0] insn_i,
    input  logic              insn_valid_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic              hazard_o,
    output logic              ex_valid_o,
    output ctrl_t             ex_ctrl_o,
    output logic [4:0]        ex_rd_o,
    output logic [4:0]        ex_rs1_o,
    output logic [4:0]        ex_rs2_o,
    output logic              mem_valid_o,
    output ctrl_t             mem_ctrl_o,
    output logic [4:0]        mem_rd_o,
    output logic              wb_valid_o,
    output logic              wb_regwren_o,
    output logic [1:0]        wb_wbsel_o,
    output logic [4:0]        wb_rd_o,
    output logic              illegal_o,
    output logic [31:0]       retired_o
);

    ctrl_t      dec_ctrl;
    logic       dec_illegal;
    logic [4:0] dec_rd;
    logic [4:0] dec_rs1;
    logic [4:0] dec_rs2;
    logic       dec_use_rs1;
    logic       dec_use_rs2;
    logic       flush_pend;
    logic       flush_eff;
    logic       take;

    ctrl_decode #(.EN_M(EN_M)) u_decode (
        .insn    (insn_i[31:0]),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal),
        .rd      (dec_rd),
        .rs1     (dec_rs1),
        .rs2     (dec_rs2),
        .use_rs1 (dec_use_rs1),
        .use_rs2 (dec_use_rs2)
    );

    // Load in EX whose destination is read by the instruction in decode.
    assign hazard_o = insn_valid_i && ex_valid_o && ex_ctrl_o.memren &&
                      (ex_rd_o != 5'd0) &&
                      ((dec_use_rs1 && (dec_rs1 == ex_rd_o)) ||
                       (dec_use_rs2 && (dec_rs2 == ex_rd_o)));

    // A flush seen during a stall is remembered and applied on release.
    assign flush_eff = flush_i || flush_pend;
    assign take      = insn_valid_i && !flush_eff && !hazard_o;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_o   <= 1'b0;
            ex_ctrl_o    <= '0;
            ex_rd_o      <= '0;
            ex_rs1_o     <= '0;
            ex_rs2_o     <= '0;
            mem_valid_o  <= 1'b0;
            mem_ctrl_o   <= '0;
            mem_rd_o     <= '0;
            wb_valid_o   <= 1'b0;
            wb_regwren_o <= 1'b0;
            wb_wbsel_o   <= '0;
            wb_rd_o      <= '0;
            illegal_o    <= 1'b0;
            flush_pend   <= 1'b0;
            retired_o    <= '0;
        end else if (stall_i) begin
            if (flush_i)
                flush_pend <= 1'b1;
        end else begin
            flush_pend   <= 1'b0;
            wb_valid_o   <= mem_valid_o;
            wb_regwren_o <= mem_ctrl_o.regwren;
            wb_wbsel_o   <= mem_ctrl_o.wbsel;
            wb_rd_o      <= mem_rd_o;
            mem_valid_o  <= ex_valid_o;
            mem_ctrl_o   <= ex_ctrl_o;
            mem_rd_o     <= ex_rd_o;
            if (take) begin
                ex_valid_o <= 1'b1;
                ex_ctrl_o  <= dec_ctrl;
                ex_rd_o    <= dec_rd;
                ex_rs1_o   <= dec_rs1;
                ex_rs2_o   <= dec_rs2;
            end else begin
                ex_valid_o <= 1'b0;
                ex_ctrl_o  <= '0;
                ex_rd_o    <= '0;
                ex_rs1_o   <= '0;
                ex_rs2_o   <= '0;
            end
            illegal_o <= take && dec_illegal;
            if (wb_valid_o)
                retired_o <= retired_o + 32'd1;
        end
    end

endmodule
